// File: rtl/binary_linear_pkg.sv
// Shared types and helpers for the binary (XNOR/popcount) fully-connected layer.
package binary_linear_pkg;

  // Output lane interpretation: full signed sum, or its sign for the next binary layer.
  typedef enum logic {
    OUT_INT  = 1'b0,
    OUT_SIGN = 1'b1
  } out_mode_e;

  localparam int unsigned STALL_CNT_WIDTH = 32;

  // Signed accumulator width able to hold +/-(in_size*in_depth).
  function automatic int acc_width(input int in_size, input int in_depth);
    return $clog2(in_size * in_depth + 1) + 1;
  endfunction

endpackage

// File: rtl/binary_xnor_popcount.sv
// Per-channel binary dot product of one beat: bit 1 = +1, bit 0 = -1.
// dot = 2*popcount(~(data ^ weight)) - IN_SIZE, as a signed value.
module binary_xnor_popcount #(
  parameter  int IN_SIZE   = 4,
  localparam int DOT_WIDTH = $clog2(IN_SIZE + 1) + 1
) (
  input  logic [IN_SIZE-1:0]          data,
  input  logic [IN_SIZE-1:0]          weight,
  output logic signed [DOT_WIDTH-1:0] dot
);

  logic [IN_SIZE-1:0]   agree;
  logic [DOT_WIDTH-1:0] pop;

  // Count agreeing lanes, then map the count onto the +/-1 sum.
  always_comb begin
    agree = ~(data ^ weight);
    pop   = '0;
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      pop = pop + DOT_WIDTH'(agree[i]);
    end
    dot = signed'((pop << 1) - DOT_WIDTH'(IN_SIZE));
  end

endmodule

// File: rtl/binary_linear_xnor_accum.sv
// Binary fully-connected layer: per-channel XNOR-popcount accumulated over
// IN_DEPTH beats, optional per-channel bias on the last beat, and an output
// register carrying either the signed sum or its sign bit.
// rst is asynchronous and active-low.
// Optional build macro BINARY_LINEAR_STALL_CNT_EN adds the stall_count port,
// counting cycles where a result is held but not taken (saturating).
module binary_linear_xnor_accum
  import binary_linear_pkg::*;
#(
  parameter  int IN_SIZE      = 4,
  parameter  int IN_DEPTH     = 3,
  parameter  int OUT_CHANNELS = 2,
  parameter  int HAS_BIAS     = 0,
  parameter  int BIAS_WIDTH   = 8,
  parameter  int OUT_MODE     = 0,
  localparam int ACC_WIDTH    = acc_width(IN_SIZE, IN_DEPTH),
  localparam int OUT_WIDTH    = ACC_WIDTH + HAS_BIAS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_SIZE-1:0]             data_in,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic [OUT_CHANNELS*IN_SIZE-1:0] weight,
  input  logic                           weight_valid,
  output logic                           weight_ready,
  input  logic signed [BIAS_WIDTH-1:0]   bias [OUT_CHANNELS],
  input  logic                           bias_valid,
  output logic                           bias_ready,
  output logic [OUT_WIDTH-1:0]           data_out [OUT_CHANNELS],
  output logic                           data_out_valid,
  input  logic                           data_out_ready
`ifdef BINARY_LINEAR_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]     stall_count
`endif
);

  localparam int DOT_WIDTH = $clog2(IN_SIZE + 1) + 1;
  localparam int CNT_WIDTH = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int SUM_WIDTH = (BIAS_WIDTH > OUT_WIDTH) ? BIAS_WIDTH : OUT_WIDTH;
  localparam bit BIAS_EN   = (HAS_BIAS != 0);
  localparam bit SIGN_OUT  = (OUT_MODE == int'(OUT_SIGN));

  logic [CNT_WIDTH-1:0]                   beat_cnt;
  logic signed [ACC_WIDTH-1:0]            acc [OUT_CHANNELS];
  logic [OUT_CHANNELS-1:0][DOT_WIDTH-1:0] dot;
  logic signed [OUT_WIDTH-1:0]            sum [OUT_CHANNELS];
  logic [OUT_WIDTH-1:0]                   result [OUT_CHANNELS];
  logic last, need_bias, space, bias_ok, out_ok, fire, fire_last;

  for (genvar c = 0; c < OUT_CHANNELS; c++) begin : g_ch
    binary_xnor_popcount #(
      .IN_SIZE(IN_SIZE)
    ) u_dot (
      .data  (data_in),
      .weight(weight[c*IN_SIZE +: IN_SIZE]),
      .dot   (dot[c])
    );
  end

  // Three-way join: a beat fires only when data, weight and (on the last
  // beat) bias are all present, and the last beat also needs output space.
  always_comb begin
    last          = (beat_cnt == CNT_WIDTH'(IN_DEPTH - 1));
    need_bias     = BIAS_EN && last;
    space         = !data_out_valid || data_out_ready;
    bias_ok       = bias_valid || !need_bias;
    out_ok        = space || !last;
    data_in_ready = weight_valid && bias_ok && out_ok;
    weight_ready  = data_in_valid && bias_ok && out_ok;
    bias_ready    = BIAS_EN ? (need_bias && data_in_valid && weight_valid && space) : 1'b1;
    fire          = data_in_valid && weight_valid && bias_ok && out_ok;
    fire_last     = fire && last;
  end

  // Final sum per channel; a bias wider than the lane is truncated, narrower is sign-extended.
  always_comb begin
    for (int unsigned c = 0; c < OUT_CHANNELS; c++) begin
      sum[c] = OUT_WIDTH'(SUM_WIDTH'(acc[c]) + SUM_WIDTH'($signed(dot[c]))
                          + (BIAS_EN ? SUM_WIDTH'(bias[c]) : SUM_WIDTH'(0)));
      if (SIGN_OUT) result[c] = OUT_WIDTH'(!sum[c][OUT_WIDTH-1]);
      else          result[c] = sum[c];
    end
  end

  // Beat counter and running sums; both restart once a vector completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      for (int unsigned c = 0; c < OUT_CHANNELS; c++) acc[c] <= '0;
    end else if (fire) begin
      if (last) begin
        beat_cnt <= '0;
        for (int unsigned c = 0; c < OUT_CHANNELS; c++) acc[c] <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        for (int unsigned c = 0; c < OUT_CHANNELS; c++) begin
          acc[c] <= acc[c] + ACC_WIDTH'($signed(dot[c]));
        end
      end
    end
  end

  // Result register: a last-beat fire reloads it (even while draining),
  // otherwise it empties when downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_valid <= 1'b0;
      for (int unsigned c = 0; c < OUT_CHANNELS; c++) data_out[c] <= '0;
    end else if (fire_last) begin
      data_out_valid <= 1'b1;
      for (int unsigned c = 0; c < OUT_CHANNELS; c++) data_out[c] <= result[c];
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

`ifdef BINARY_LINEAR_STALL_CNT_EN
  // Saturating count of cycles with a result waiting on downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (data_out_valid && !data_out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end
`endif

endmodule
